// File: rtl/layer_stream_driver.sv
// Streams V input vectors of N words to a layer over valid/ready and collects
// the M result words per vector into a host-readable result memory.
module layer_stream_driver #(
  parameter int N = 6,
  parameter int M = 8,
  parameter int T = 16,
  parameter int V = 4,
  localparam int LAW = $clog2(V*N),
  localparam int RAW = $clog2(V*M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_en,
  input  logic [LAW-1:0] load_addr,
  input  logic [T-1:0]   load_data,
  input  logic           start,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [T-1:0]   m_data,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [T-1:0]   s_data,
  input  logic [RAW-1:0] rd_addr,
  output logic [T-1:0]   rd_data,
  output logic           busy,
  output logic           done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (M > 1) ? $clog2(M) : 1;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N-1);
  localparam logic [JW-1:0] J_LAST = JW'(M-1);
  localparam logic [VW-1:0] V_LAST = VW'(V-1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t        state, state_nxt;
  logic [VW-1:0] v, v_nxt;
  logic [IW-1:0] i, i_nxt;
  logic [JW-1:0] j, j_nxt;

  logic [T-1:0]   in_mem  [V*N];
  logic [T-1:0]   res_mem [V*M];
  logic [LAW-1:0] in_idx;
  logic [RAW-1:0] res_idx;

  assign in_idx  = LAW'(int'(v)*N + int'(i));
  assign res_idx = RAW'(int'(v)*M + int'(j));

  // m_data is a direct read of the current word, so a load in the same cycle
  // as start is already visible on the first transfer.
  assign m_data = (state == SEND) ? in_mem[in_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      v     <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      state <= state_nxt;
      v     <= v_nxt;
      i     <= i_nxt;
      j     <= j_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    i_nxt     = i;
    j_nxt     = j;
    m_valid   = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = SEND;
          v_nxt     = '0;
          i_nxt     = '0;
          j_nxt     = '0;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (m_ready) begin
          if (i == I_LAST) begin
            i_nxt     = '0;
            state_nxt = RECV;
          end else begin
            i_nxt = i + 1'b1;
          end
        end
      end
      RECV: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (j == J_LAST) begin
            j_nxt = '0;
            if (v == V_LAST) begin
              state_nxt = DONE;
            end else begin
              v_nxt     = v + 1'b1;
              state_nxt = SEND;
            end
          end else begin
            j_nxt = j + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy && (int'(load_addr) < V*N))
      in_mem[load_addr] <= load_data;
    if (state == RECV && s_valid)
      res_mem[res_idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (int'(rd_addr) < V*M)
      rd_data <= res_mem[rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_layer_stream_driver.sv
// Directed bench for layer_stream_driver (N=6, M=8, V=2): cycle table for a full
// run plus hand sequences for readback, mid-run reset and load/start overlap.
module tb_layer_stream_driver;

  logic        clk = 1'b0;
  logic        reset, load_en, start, m_valid, m_ready, s_valid, s_ready, busy, done;
  logic [3:0]  load_addr, rd_addr;
  logic [15:0] load_data, m_data, s_data, rd_data;

  int checks = 0;
  int errors = 0;

  layer_stream_driver #(.N(6), .M(8), .T(16), .V(2)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, le;
    logic [3:0]  la;
    logic [15:0] ld;
    logic        mr, sv;
    logic [15:0] sd;
    logic        mv;
    logic [15:0] md;
    logic        sr, bsy, dn;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sent[$];

  function automatic vec_t row(input int st, le, la, ld, mr, sv, sd, mv, md, sr, bsy, dn);
    vec_t r;
    r.st = 1'(st);  r.le = 1'(le);  r.la = 4'(la);  r.ld = 16'(ld);
    r.mr = 1'(mr);  r.sv = 1'(sv);  r.sd = 16'(sd);
    r.mv = 1'(mv);  r.md = 16'(md); r.sr = 1'(sr);  r.bsy = 1'(bsy); r.dn = 1'(dn);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  initial begin
    int sv0[11] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1};
    int sv1[9]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    int mr1[9]  = '{1, 0, 0, 1, 0, 1, 1, 1, 1};
    int md1[9]  = '{7, 8, 8, 8, 9, 9, 10, 11, 12};
    int d, n;

    // vector 0, free flow; a junk result offered during SEND must be ignored
    tbl.push_back(row(0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 999, 1, 2, 0, 1, 0));
    for (int w = 3; w <= 6; w++) tbl.push_back(row(0, 0, 0, 0, 1, 0, 0, 1, w, 0, 1, 0));
    d = 100;
    for (int k = 0; k < 11; k++) begin
      tbl.push_back(row(0, 0, 0, 0, 0, sv0[k], sv0[k] ? d : 0, 0, 0, 1, 1, 0));
      if (sv0[k] != 0) d++;
    end
    // vector 1 under backpressure; start (row 1) and load (row 2) while busy
    for (int k = 0; k < 9; k++)
      tbl.push_back(row(k == 1, k == 2, 0, 77, mr1[k], 0, 0, 1, md1[k], 0, 1, 0));
    d = 200;
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(row(0, 0, 0, 0, 0, sv1[k], sv1[k] ? d : 0, 0, 0, 1, 1, 0));
      if (sv1[k] != 0) d++;
    end
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 555, 0, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 556, 0, 0, 0, 0, 1));

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    m_ready = 1'b0; s_valid = 1'b0; s_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst s_ready", s_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst m_data", m_data, 0);
    chk("rst rd_data", rd_data, 0);

    for (int a = 0; a < 12; a++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = 4'(a); load_data = 16'(a + 1);
    end
    @(negedge clk);
    load_en = 1'b0;
    start = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      start = tbl[k].st; load_en = tbl[k].le; load_addr = tbl[k].la; load_data = tbl[k].ld;
      m_ready = tbl[k].mr; s_valid = tbl[k].sv; s_data = tbl[k].sd;
      #1;
      chk($sformatf("row%0d m_valid", k), m_valid, tbl[k].mv);
      chk($sformatf("row%0d m_data", k), m_data, tbl[k].md);
      chk($sformatf("row%0d s_ready", k), s_ready, tbl[k].sr);
      chk($sformatf("row%0d busy", k), busy, tbl[k].bsy);
      chk($sformatf("row%0d done", k), done, tbl[k].dn);
      if (tbl[k].mr && m_valid) sent.push_back(m_data);
    end
    start = 1'b0; load_en = 1'b0; m_ready = 1'b0; s_valid = 1'b0;

    chk("sent count", sent.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < sent.size()) chk($sformatf("sent[%0d]", k), sent[k], k + 1);

    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      @(negedge clk);
      #1;
      chk($sformatf("res[%0d]", a), rd_data, (a < 8) ? 100 + a : 200 + a - 8);
    end
    chk("done held", done, 1);

    // second run: word 0 must still be 1 despite the load attempted while busy
    @(negedge clk);
    start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("run2 m_data0", m_data, 1);
    chk("run2 done clr", done, 0);
    chk("run2 busy", busy, 1);
    @(negedge clk);
    #1;
    chk("run2 m_data1", m_data, 2);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst m_valid", m_valid, 0);
    chk("midrst s_ready", s_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst m_data", m_data, 0);
    chk("midrst rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    rd_addr = 4'd3;
    @(negedge clk);
    #1;
    chk("retained res[3]", rd_data, 103);

    // out-of-range load, then load and start together
    load_en = 1'b1; load_addr = 4'd12; load_data = 16'd99;
    @(negedge clk);
    load_addr = 4'd0; load_data = 16'd55; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    #1;
    chk("edge m_valid", m_valid, 1);
    chk("edge m_data0", m_data, 55);
    @(negedge clk);
    #1;
    chk("edge m_data1", m_data, 2);

    n = 0;
    while (!s_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach recv", s_ready, 1);
    // write and read of the same address in one cycle returns the old word
    s_valid = 1'b1; s_data = 16'd300; rd_addr = 4'd0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("rd old on write", rd_data, 100);
    @(negedge clk);
    #1;
    chk("rd new after write", rd_data, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
